// File: rtl/add42_pkg.sv
// add42_pkg: shared types and defaults for the add-42 arbiter slice.
//   state_e        : controller states (IDLE, ADD, OUT)
//   SRC_A / SRC_B  : source tag values carried alongside each result
//   DEFAULT_WIDTH  : default operand/result width
//   DEFAULT_ADDEND : default constant added to every operand
package add42_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_ADDEND = 42;

endpackage

// File: rtl/add42_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_a_i, req_b_i    : request lines
//   advance_i           : strobe; the current grant is taken this cycle
//   gnt_a_o, gnt_b_o    : one-hot grant (both low when nothing requests)
// The last pointer remembers the most recently taken grant. On a tie the
// other channel wins; it resets to B so A wins the first tie.
module rr_arbiter2
  import add42_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic advance_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_q;
  logic last_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (req_a_i && req_b_i) begin
      if (last_q == SRC_B) gnt_a_o = 1'b1;
      else                 gnt_b_o = 1'b1;
    end else if (req_a_i) begin
      gnt_a_o = 1'b1;
    end else if (req_b_i) begin
      gnt_b_o = 1'b1;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance_i && gnt_a_o)      last_d = SRC_A;
    else if (advance_i && gnt_b_o) last_d = SRC_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SRC_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/add42_arbiter.sv
// add42_arbiter: one registered add-ADDEND datapath shared by two channels.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   ena                         : enable; low blocks new grants
//   a_valid/a_data/a_ready      : channel A operand handshake
//   b_valid/b_data/b_ready      : channel B operand handshake
//   res_valid/res_ready         : result handshake
//   res_data/res_carry/res_src  : sum mod 2^WIDTH, carry out, source tag
//   busy                        : high outside IDLE
//   done_cnt                    : delivered results, wraps at 256
// Flow: IDLE (grant + capture) -> ADD (register sum) -> OUT (hold until taken).
// ADDEND is expected to fit in WIDTH bits.
module add42_arbiter
  import add42_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDEND = DEFAULT_ADDEND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_src,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  localparam logic [WIDTH:0] ADDEND_EXT = (WIDTH + 1)'(ADDEND);

  state_e           state_q;
  logic [WIDTH-1:0] op_q;
  logic             src_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_carry_q;
  logic             res_src_q;
  logic             busy_q;
  logic [7:0]       done_cnt_q;

  logic gnt_a;
  logic gnt_b;
  logic idle_open;
  logic grant;

  // NOTE: state sits at IDLE during reset, so the readies are also gated by
  // rst_n itself; otherwise a requester could see ready while reset is held.
  assign idle_open = rst_n & ena & (state_q == IDLE);
  assign grant     = idle_open & (a_valid | b_valid);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a_i   (a_valid),
    .req_b_i   (b_valid),
    .advance_i (grant),
    .gnt_a_o   (gnt_a),
    .gnt_b_o   (gnt_b)
  );

  assign a_ready = idle_open & gnt_a;
  assign b_ready = idle_open & gnt_b;

  // NOTE: clocked state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      src_q       <= SRC_A;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_src_q   <= SRC_A;
      busy_q      <= 1'b0;
      done_cnt_q  <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            op_q    <= gnt_b ? b_data : a_data;
            src_q   <= gnt_b ? SRC_B : SRC_A;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          {res_carry_q, res_data_q} <= {1'b0, op_q} + ADDEND_EXT;
          res_src_q   <= src_q;
          res_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          // Result registers are untouched here, so they hold under backpressure.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= done_cnt_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_src   = res_src_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_add42_arbiter.sv
// tb_add42_arbiter: directed bench with a result scoreboard for add42_arbiter.
module tb_add42_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       b_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       res_ready = 1'b0;
  logic       a_ready;
  logic       b_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_src;
  logic       busy;
  logic [7:0] done_cnt;

  add42_arbiter #(.WIDTH(8), .ADDEND(42)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_src   (res_src),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a_acc = 0;
  int   b_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic src);
    logic [8:0] sum;
    sum = {1'b0, d} + 9'd42;
    return '{data: sum[7:0], carry: sum[8], src: src};
  endfunction

  // One clock: sample at the falling edge (handshakes, scoreboard), then
  // return 1ns after the rising edge so the caller can drive new inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    check("ready_onehot", a_ready & b_ready, 0);
    if (a_valid && a_ready) a_acc++;
    if (b_valid && b_ready) b_acc++;
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", res_valid, 0);
      end else begin
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_carry", res_carry, e.carry);
        check("res_src", res_src, e.src);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held_data;

    // Reset state, with requests already present while reset is held.
    ena = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #12;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 8'h00);
    check("rst_res_carry", res_carry, 0);
    check("rst_res_src", res_src, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();

    // A only, 0x05 -> 0x2F.
    res_ready = 1'b1; a_data = 8'h05; a_valid = 1'b1;
    sb.push_back(model(8'h05, 1'b0));
    a_acc = 0;
    step();
    a_valid = 1'b0;
    check("a_accept_once", a_acc, 1);
    check("add_busy", busy, 1);
    check("add_res_valid", res_valid, 0);
    step();
    check("out_res_valid", res_valid, 1);
    check("out_res_data", res_data, 8'h2F);
    drain(5);
    check("a_only_done_cnt", done_cnt, 1);
    check("a_only_busy", busy, 0);

    // B only with carry, 0xE0 -> 0x0A carry 1.
    b_data = 8'hE0; b_valid = 1'b1; b_acc = 0;
    sb.push_back(model(8'hE0, 1'b1));
    step();
    b_valid = 1'b0;
    drain(10);
    check("b_accept_once", b_acc, 1);
    check("carry_done_cnt", done_cnt, 2);

    // Fairness from reset: tie held for four grants -> A, B, A, B.
    do_reset();
    check("fair_rst_done_cnt", done_cnt, 0);
    a_data = 8'h11; b_data = 8'h22; a_acc = 0; b_acc = 0;
    sb.push_back(model(8'h11, 1'b0));
    sb.push_back(model(8'h22, 1'b1));
    sb.push_back(model(8'h11, 1'b0));
    sb.push_back(model(8'h22, 1'b1));
    a_valid = 1'b1; b_valid = 1'b1;
    drain(40);
    a_valid = 1'b0; b_valid = 1'b0;
    check("fair_done_cnt", done_cnt, 4);
    check("fair_a_grants", a_acc, 2);
    check("fair_b_grants", b_acc, 2);

    // Backpressure: last grant went to B, so the tie goes to A (0x80 -> 0xAA).
    res_ready = 1'b0; a_data = 8'h80; b_data = 8'h10;
    a_valid = 1'b1; b_valid = 1'b1; a_acc = 0; b_acc = 0;
    sb.push_back(model(8'h80, 1'b0));
    sb.push_back(model(8'h10, 1'b1));
    step();
    a_valid = 1'b0;
    check("bp_a_first", a_acc, 1);
    step();
    held_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, held_data);
      check("bp_res_carry", res_carry, 0);
      check("bp_res_src", res_src, 0);
      check("bp_a_ready", a_ready, 0);
      check("bp_b_ready", b_ready, 0);
      check("bp_busy", busy, 1);
      step();
    end
    check("bp_no_b_grant", b_acc, 0);
    res_ready = 1'b1;
    step();
    check("bp_single_done", done_cnt, 5);
    check("bp_after_valid", res_valid, 0);
    step();
    b_valid = 1'b0;
    check("bp_b_granted", b_acc, 1);
    drain(10);
    check("bp_done_cnt", done_cnt, 6);

    // Enable gating.
    ena = 1'b0; a_data = 8'h01; a_valid = 1'b1; a_acc = 0;
    for (int i = 0; i < 5; i++) begin
      check("ena_low_ready", a_ready, 0);
      check("ena_low_busy", busy, 0);
      step();
    end
    check("ena_low_no_grant", a_acc, 0);
    ena = 1'b1;
    sb.push_back(model(8'h01, 1'b0));
    step();
    check("ena_grant", a_acc, 1);
    a_valid = 1'b0;
    ena = 1'b0;
    drain(10);
    check("ena_drop_done_cnt", done_cnt, 7);
    ena = 1'b1;

    // Reset in OUT: in-flight result is lost.
    res_ready = 1'b0; a_data = 8'h03; b_data = 8'h04;
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("mid_res_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_done_cnt", done_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_data", res_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b1; a_acc = 0; b_acc = 0;
    sb.push_back(model(8'h03, 1'b0));
    sb.push_back(model(8'h04, 1'b1));
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    check("post_rst_a_first", a_acc, 1);
    drain(20);
    a_valid = 1'b0; b_valid = 1'b0;
    check("post_rst_done_cnt", done_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add42_arbiter.md
# add42_arbiter

Shares one registered add-42 datapath between two requester channels (A, B) with round-robin arbitration and valid/ready handshakes on every side. Each accepted 8-bit operand is added to a constant, and the 8-bit sum plus carry and a source tag are presented on a single result port. It sits between the pin-level input decoding of the TinyTapeout top (`tt_um_project`) and its output muxing, and replaces the direct combinational adder path.

## Interface
- `WIDTH`, 8: operand/result width.
- `ADDEND`, 42: constant added to every operand; must fit in `WIDTH` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; low blocks new grants.
- `a_valid`  in  1  channel A has an operand.
- `a_data`  in  WIDTH  channel A operand.
- `a_ready`  out  1  channel A operand accepted this cycle when high with `a_valid`.
- `b_valid`  in  1  channel B has an operand.
- `b_data`  in  WIDTH  channel B operand.
- `b_ready`  out  1  channel B operand accepted this cycle when high with `b_valid`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  WIDTH  (operand + ADDEND) mod 2^WIDTH.
- `res_carry`  out  1  carry out of the addition.
- `res_src`  out  1  0 = from A, 1 = from B.
- `busy`  out  1  high in any state other than IDLE.
- `done_cnt`  out  8  count of delivered results (`res_valid & res_ready`); wraps 255 -> 0.

## Operation
- FSM states: IDLE, ADD, OUT.
- IDLE: if `ena` and any valid, grant one channel (its ready is high this cycle), capture operand and source, go to ADD. Otherwise stay.
- ADD: register the (WIDTH+1)-bit sum operand+ADDEND into {`res_carry`,`res_data`}, go to OUT.
- OUT: `res_valid`=1. On `res_ready`: increment `done_cnt`, go to IDLE. Otherwise hold all result outputs stable.
- Readies are combinational from state, `ena`, valids, and the priority pointer. They are high only in IDLE, only for the granted channel, and never both at once.
- Round-robin: a 1-bit `last` pointer holds the most recently granted channel. If both channels are valid, grant the other one. If one is valid, grant it. `last` updates only on a grant.
- Requester rule: `x_valid` must not depend on `x_ready`. Data stays stable while valid and not yet accepted. The block does not check this.
- `ena` low: no grants from IDLE. An operation already in ADD/OUT completes normally.

## Timing
- Reset values: state IDLE, `last`=B (A wins the first tie), `res_valid`=0, `res_data`=0, `res_carry`=0, `res_src`=0, `busy`=0, `done_cnt`=0. `a_ready` and `b_ready` are 0 while `rst_n` is low.
- Latency: accept at edge N; `res_valid` is high from cycle N+2.
- Throughput: at most one result per 3 cycles, when `res_ready` is held high.
- Backpressure: OUT is held indefinitely with no change to outputs. Neither channel is granted meanwhile.
- Simultaneous A and B valid: exactly one is granted. The other is served on the next IDLE if it is still valid.
- Reset asserted mid-operation: the operation is aborted immediately (asynchronous), the in-flight result is lost, and outputs return to reset values.
- Carry example: operand 0xE0 + 42 -> `res_data`=0x0A, `res_carry`=1.

## Structure
- Package `add42_pkg`: state enum (IDLE/ADD/OUT), `SRC_A`=1'b0, `SRC_B`=1'b1, default `ADDEND`=42, default `WIDTH`=8.
- Sub-module `rr_arbiter2`: two request inputs, `advance` strobe, one-hot grant outputs, internal `last` pointer with async reset to B.
- Top `add42_arbiter`: FSM, operand/source capture, sum register, `done_cnt`.

## Test plan
- Reset, then A only: `a_data`=0x05 with `res_ready`=1 -> `a_ready` pulses once; 2 cycles later `res_data`=0x2F, `res_carry`=0, `res_src`=0; `done_cnt`=1.
- Carry: B only, `b_data`=0xE0 -> `res_data`=0x0A, `res_carry`=1, `res_src`=1.
- Fairness: A and B held valid for 4 grants after reset -> source order A, B, A, B; `done_cnt`=4.
- Backpressure: `res_ready`=0 for 10 cycles in OUT -> `res_valid` stays 1, result outputs stable, both readies 0, `busy`=1; releasing `res_ready` completes a single transfer.
- Enable: `ena`=0 with A valid -> no grant for 5 cycles; raise `ena` -> grant on the next cycle. Dropping `ena` during ADD still delivers that result.
- Reset mid-op: assert `rst_n`=0 in OUT -> `res_valid`=0 immediately, `done_cnt`=0. After release, an A/B tie grants A first.
